// File: rtl/ram_if.sv
// ram_if: one port of the shared RAM. Carries the port wires and the storage
// behind them. Write-first: a write and a read of the same address on the
// same edge return the new data. Read data is registered (one-edge latency).
interface ram_if #(
    parameter int DEPTH = 256,
    parameter int AWID  = 8,
    parameter int DWID  = 16
) (
    input logic clk
);
    logic            we;
    logic [AWID-1:0] addr;
    logic [DWID-1:0] din;
    logic [DWID-1:0] dout;

    logic [DWID-1:0] mem_q [0:DEPTH-1];

    // Storage update and registered write-first read
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
            dout        <= din;
        end else begin
            dout        <= mem_q[addr];
        end
    end

    modport cntl (input clk, input dout, output we, output addr, output din);
endinterface

// File: rtl/ram_arb.sv
// ram_arb: round-robin arbiter sharing one ram_if port among NREQ requesters.
// Two-stage pipeline: stage 1 drives the RAM port from registers, stage 2
// aligns the read tag with the registered RAM output.
// Optional macro RAM_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin.
//
// Handshake: a command on requester i transfers in the cycle where
// req_valid[i] and req_ready[i] are both high at the rising edge. ready is
// one-hot or zero, never depends on anything but valid/arb_en/rst_n/pointer,
// and the requester must hold valid/we/addr/din stable until it transfers.
// Responses have no backpressure and must be consumed when rsp_valid is high.
module ram_arb #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int DEPTH = 256,
    parameter int AWID  = 8,
    parameter int DWID  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arb_en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AWID-1:0] req_addr,
    input  logic [NREQ*DWID-1:0] req_din,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [DWID-1:0]      rsp_data,
    output logic                 busy,
    ram_if.cntl                  mem
);

    // Parameter sanity at elaboration
    if (DEPTH < 1 || DEPTH > (1 << AWID) || NREQ < 2 || NREQ > (1 << IDW)) begin : g_param_check
        $error("ram_arb: inconsistent DEPTH/AWID or NREQ/IDW parameters");
    end

    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;
    logic            accept;
    logic            sel_we;
    logic [AWID-1:0] sel_addr;
    logic [DWID-1:0] sel_din;

    logic            s1_vld;
    logic            s1_rd;
    logic [IDW-1:0]  s1_id;
    logic            we_q;
    logic [AWID-1:0] addr_q;
    logic [DWID-1:0] din_q;

    logic            s2_vld;
    logic            s2_rd;
    logic [IDW-1:0]  s2_id;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: iterate downward so the lowest valid index is written last
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q;
    int             cand;

    // Round-robin: the first valid requester searching upward from ptr+1;
    // iterating the offset downward leaves the nearest one as the final write
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(cand);
            end
        end
    end

    // Pointer remembers the last winner; reset makes requester 0 first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= IDW'(NREQ - 1);
        end else if (accept) begin
            ptr_q <= gnt_id;
        end
    end
`endif

    // Ready and winner command fields
    always_comb begin
        accept    = gnt_found && arb_en && rst_n;
        req_ready = accept ? (NREQ'(1) << gnt_id) : '0;
        sel_we    = req_we[gnt_id];
        sel_addr  = req_addr[int'(gnt_id)*AWID +: AWID];
        sel_din   = req_din[int'(gnt_id)*DWID +: DWID];
    end

    // Stage 1: registered RAM port; addr/din hold when nothing is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_rd  <= 1'b0;
            s1_id  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            s1_vld <= accept;
            s1_rd  <= accept && !sel_we;
            we_q   <= accept && sel_we;
            if (accept) begin
                s1_id  <= gnt_id;
                addr_q <= sel_addr;
                din_q  <= sel_din;
            end
        end
    end

    // Stage 2: tag travels alongside the RAM read latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_rd  <= 1'b0;
            s2_id  <= '0;
        end else begin
            s2_vld <= s1_vld;
            s2_rd  <= s1_rd;
            s2_id  <= s1_id;
        end
    end

    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.din   = din_q;

    assign rsp_valid = s2_rd;
    assign rsp_id    = s2_id;
    assign rsp_data  = mem.dout;
    assign busy      = s1_vld || s2_vld;

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: scenario tasks for ram_arb with a response scoreboard. Read
// accepts push {expected cycle, id, data} from a bench-side memory model;
// responses pop and compare.
module tb_ram_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int AWID = 8;
    localparam int DWID = 16;
    localparam int W    = 32 + IDW + DWID;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 arb_en = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_we = '0;
    logic [NREQ*AWID-1:0] req_addr = '0;
    logic [NREQ*DWID-1:0] req_din = '0;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [DWID-1:0]      rsp_data;
    logic                 busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [W-1:0]    exp_q[$];
    logic [DWID-1:0] model [0:255];

    ram_if #(.DEPTH(256), .AWID(AWID), .DWID(DWID)) mem_bus (.clk(clk));

    ram_arb #(.NREQ(NREQ), .IDW(IDW), .DEPTH(256), .AWID(AWID), .DWID(DWID)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .mem(mem_bus)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: check responses, then record this cycle's accepts
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rsp_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h at cycle %0d, required no response", rsp_id, rsp_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (rsp_id !== e[DWID +: IDW] || rsp_data !== e[DWID-1:0] || cyc !== int'(e[W-1 -: 32])) begin
                    miscompares++;
                    $display("FAIL rsp: got id=%0d data=%h cycle=%0d, required id=%0d data=%h cycle=%0d",
                             rsp_id, rsp_data, cyc, e[DWID +: IDW], e[DWID-1:0], int'(e[W-1 -: 32]));
                end
            end
        end
        if (rst_n !== 1'b1) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i] === 1'b1) begin
                    if (req_we[i]) model[req_addr[i*AWID +: AWID]] = req_din[i*DWID +: DWID];
                    else exp_q.push_back({32'(cyc + 2), IDW'(i), model[req_addr[i*AWID +: AWID]]});
                end
            end
        end
    end

    // Driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AWID-1:0] a,
                           input logic [DWID-1:0] d, input logic v);
        req_valid[i]             = v;
        req_we[i]                = we;
        req_addr[i*AWID +: AWID] = a;
        req_din[i*DWID +: DWID]  = d;
    endtask

    // Issue one command and return at the cycle after its accept
    task automatic do_cmd(input int i, input logic we, input logic [AWID-1:0] a,
                          input logic [DWID-1:0] d);
        bit ok = 0;
        set_req(i, we, a, d, 1'b1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i] === 1'b1) begin
                ok = 1;
                break;
            end
        end
        tick();
        req_valid[i] = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL cmd_timeout: requester %0d got no ready in 20 cycles, required accept", i);
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 10; n++) begin
            if (exp_q.size() == 0 && busy === 1'b0) break;
            tick();
        end
        vectors++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: %0d responses outstanding busy=%b, required 0 and 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        arb_en = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AWID'(i), '0, 1'b1);
        repeat (3) tick();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b rsp_id=%0d busy=%b, required 0000 0 0 0", req_ready, rsp_valid, rsp_id, busy);
        end
        vectors++;
        if (mem_bus.we !== 1'b0 || mem_bus.addr !== 8'h00 || mem_bus.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mem: we=%b addr=%h din=%h, required 0 00 0000", mem_bus.we, mem_bus.addr, mem_bus.din);
        end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        do_cmd(0, 1'b1, 8'h10, 16'hBEEF);
        vectors++;
        if (mem_bus.we !== 1'b1 || mem_bus.addr !== 8'h10 || mem_bus.din !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL wr_stage1: we=%b addr=%h din=%h, required 1 10 beef", mem_bus.we, mem_bus.addr, mem_bus.din);
        end
        tick();
        vectors++;
        if (mem_bus.we !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_we_drop: we=%b, required 0", mem_bus.we);
        end
        do_cmd(0, 1'b0, 8'h10, 16'h0000);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        do_cmd(0, 1'b1, 8'h00, 16'h5A5A);
        set_req(0, 1'b1, 8'hFF, 16'h1234, 1'b1);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL raw_wr_accept: ready=%b, required 0001", req_ready);
        end
        tick();
        set_req(0, 1'b0, 8'hFF, 16'h0000, 1'b1);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL raw_rd_accept: ready=%b, required 0001", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        do_cmd(0, 1'b0, 8'h00, 16'h0000);
        wait_drain();
    endtask

    task automatic test_round_robin();
        int g;
        for (int i = 0; i < NREQ; i++) do_cmd(i, 1'b1, AWID'(8'h20 + i), DWID'(16'hA000 + i));
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AWID'(8'h20 + i), '0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = c % NREQ;
`endif
            vectors++;
            if (req_ready !== NREQ'(1 << g)) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: ready=%b, required %b", c, req_ready, NREQ'(1 << g));
            end
            tick();
        end
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_pair();
        int g;
        set_req(1, 1'b0, 8'h21, '0, 1'b1);
        set_req(3, 1'b0, 8'h23, '0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
            g = 1;
`else
            g = (c % 2 == 0) ? 1 : 3;
`endif
            vectors++;
            if (req_ready !== NREQ'(1 << g)) begin
                miscompares++;
                $display("FAIL pair_grant[%0d]: ready=%b, required %b", c, req_ready, NREQ'(1 << g));
            end
            tick();
        end
        req_valid = '0;
        wait_drain();
    endtask

    task automatic test_arb_en();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AWID'(8'h20 + i), '0, 1'b1);
        tick();
        tick();
        arb_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL arb_off_ready[%0d]: ready=%b, required 0000", c, req_ready);
            end
            if (c == 0) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL arb_off_busy_hi: busy=%b, required 1", busy);
                end
            end
            if (c == 2) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL arb_off_busy_lo: busy=%b, required 0", busy);
                end
            end
            tick();
        end
        req_valid = '0;
        arb_en = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AWID'(8'h20 + i), '0, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs: rsp_valid=%b rsp_id=%0d busy=%b, required 0 0 0", rsp_valid, rsp_id, busy);
        end
        vectors++;
        if (mem_bus.we !== 1'b0 || mem_bus.addr !== 8'h00 || mem_bus.din !== 16'h0000) begin
            miscompares++;
            $display("FAIL midrst_mem: we=%b addr=%h din=%h, required 0 00 0000", mem_bus.we, mem_bus.addr, mem_bus.din);
        end
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_first_grant: ready=%b, required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (4) tick();
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_round_robin();
        test_pair();
        test_arb_en();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1);
    end

endmodule
